// File: rtl/adder_result_pack.sv
// FP adder output stage: special-case resolution, IEEE-754 packing, 2-entry skid buffer.
// Optional DENORM_EN: pass exp=0 mantissas through as subnormals instead of flushing.
module adder_result_pack #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   sign_in,
    input  logic [EXP_W-1:0]       exp_in,
    input  logic                   max_exp_in,
    input  logic [MAN_W-1:0]       mant_in,
    input  logic                   nan_in,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W:0]   result,
    output logic                   ovf_o,
    output logic                   unf_o,
    output logic                   zero_o,
    output logic [1:0]             sticky_flags,
    input  logic                   flag_clr
);

    localparam int RES_W = 1 + EXP_W + MAN_W;

    typedef struct packed {
        logic [RES_W-1:0] word;
        logic             ovf;
        logic             unf;
        logic             zero;
    } entry_t;

    entry_t     mem [2];
    entry_t     packed_e;
    entry_t     head;
    logic [1:0] count;
    logic [1:0] count_next;
    logic       wr_ptr;
    logic       rd_ptr;
    logic       push;
    logic       pop;
    logic       exp_ones;
    logic       exp_zero;
    logic       mant_nz;

    assign push     = in_valid & in_ready;
    assign pop      = out_valid & out_ready;
    assign exp_ones = &exp_in;
    assign exp_zero = ~|exp_in;
    assign mant_nz  = |mant_in;

    // Earlier rows win: NaN beats overflow beats the exp=0 cases.
    always_comb begin
        packed_e = '0;
        priority case (1'b1)
            nan_in: begin
                packed_e.word = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
            end
            (max_exp_in | exp_ones): begin
                packed_e.word = {sign_in, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                packed_e.ovf  = 1'b1;
            end
            exp_zero: begin
`ifdef DENORM_EN
                packed_e.word = {sign_in, {EXP_W{1'b0}}, mant_in};
                packed_e.unf  = mant_nz;
                packed_e.zero = ~mant_nz;
`else
                packed_e.word = {sign_in, {EXP_W{1'b0}}, {MAN_W{1'b0}}};
                packed_e.unf  = mant_nz;
                packed_e.zero = 1'b1;
`endif
            end
            default: begin
                packed_e.word = {sign_in, exp_in, mant_in};
            end
        endcase
    end

    always_comb begin
        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + 2'd1;
            2'b01:   count_next = count - 2'd1;
            default: count_next = count;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count    <= '0;
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            in_ready <= 1'b1;
            mem[0]   <= '0;
            mem[1]   <= '0;
        end else begin
            count    <= count_next;
            in_ready <= (count_next < 2'd2);
            if (push) begin
                mem[wr_ptr] <= packed_e;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
        end
    end

    // Set beats clear so a flag popped in the clearing cycle is never lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_flags <= '0;
        end else begin
            sticky_flags <= (flag_clr ? 2'b00 : sticky_flags)
                          | (pop ? {head.ovf, head.unf} : 2'b00);
        end
    end

    assign head      = mem[rd_ptr];
    assign out_valid = (count != 2'd0);
    assign result    = out_valid ? head.word : '0;
    assign ovf_o     = out_valid & head.ovf;
    assign unf_o     = out_valid & head.unf;
    assign zero_o    = out_valid & head.zero;

endmodule

// File: tb/tb_adder_result_pack.sv
// Directed self-checking bench for adder_result_pack.
// Build with +define+DENORM_EN to check the subnormal pass-through variant.
module tb_adder_result_pack;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        sign_in;
    logic [7:0]  exp_in;
    logic        max_exp_in;
    logic [22:0] mant_in;
    logic        nan_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        ovf_o;
    logic        unf_o;
    logic        zero_o;
    logic [1:0]  sticky_flags;
    logic        flag_clr;

    int checks;
    int errors;

    adder_result_pack #(.EXP_W(8), .MAN_W(23)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .sign_in      (sign_in),
        .exp_in       (exp_in),
        .max_exp_in   (max_exp_in),
        .mant_in      (mant_in),
        .nan_in       (nan_in),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .result       (result),
        .ovf_o        (ovf_o),
        .unf_o        (unf_o),
        .zero_o       (zero_o),
        .sticky_flags (sticky_flags),
        .flag_clr     (flag_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic v, input logic s, input logic [7:0] e,
                         input logic mx, input logic [22:0] m, input logic n);
        in_valid   = v;
        sign_in    = s;
        exp_in     = e;
        max_exp_in = mx;
        mant_in    = m;
        nan_in     = n;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 8'h00, 1'b0, 23'h0, 1'b0);
        out_ready = 1'b0;
        flag_clr  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== 32'h0 ||
            sticky_flags !== 2'b00 || {ovf_o, unf_o, zero_o} !== 3'b000) begin
            errors++;
            $display("FAIL reset: rdy=%b vld=%b res=%h st=%b fl=%b%b%b want 1 0 0 00 000",
                     in_ready, out_valid, result, sticky_flags, ovf_o, unf_o, zero_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_normal();
        @(negedge clk);
        out_ready = 1'b1;
        drive(1'b1, 1'b0, 8'h80, 1'b0, 23'h400000, 1'b0);
        step();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || result !== 32'h40400000 ||
            {ovf_o, unf_o, zero_o} !== 3'b000) begin
            errors++;
            $display("FAIL normal: vld=%b res=%h fl=%b%b%b want 1 40400000 000",
                     out_valid, result, ovf_o, unf_o, zero_o);
        end
        step();
        checks++;
        if (out_valid !== 1'b0 || sticky_flags !== 2'b00) begin
            errors++;
            $display("FAIL normal_pop: vld=%b st=%b want 0 00", out_valid, sticky_flags);
        end
    endtask

    task automatic test_overflow();
        @(negedge clk);
        out_ready = 1'b0;
        drive(1'b1, 1'b1, 8'h10, 1'b1, 23'h123456, 1'b0);
        step();
        in_valid = 1'b0;
        checks++;
        if (result !== 32'hFF800000 || ovf_o !== 1'b1 || sticky_flags !== 2'b00) begin
            errors++;
            $display("FAIL ovf_push: res=%h ovf=%b st=%b want ff800000 1 00",
                     result, ovf_o, sticky_flags);
        end
        step();
        checks++;
        if (result !== 32'hFF800000 || ovf_o !== 1'b1) begin
            errors++;
            $display("FAIL ovf_hold: res=%h ovf=%b want ff800000 1", result, ovf_o);
        end
        @(negedge clk);
        out_ready = 1'b1;
        step();
        checks++;
        if (sticky_flags !== 2'b10 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL ovf_sticky: st=%b vld=%b want 10 0", sticky_flags, out_valid);
        end
        @(negedge clk);
        drive(1'b1, 1'b0, 8'hFF, 1'b0, 23'h000001, 1'b0);
        step();
        in_valid = 1'b0;
        checks++;
        if (result !== 32'h7F800000 || ovf_o !== 1'b1) begin
            errors++;
            $display("FAIL exp_ones: res=%h ovf=%b want 7f800000 1", result, ovf_o);
        end
        step();
    endtask

    task automatic test_underflow();
        @(negedge clk);
        out_ready = 1'b0;
        drive(1'b1, 1'b0, 8'h00, 1'b0, 23'h000001, 1'b0);
        step();
        in_valid = 1'b0;
        checks++;
`ifdef DENORM_EN
        if (result !== 32'h00000001 || unf_o !== 1'b1 || zero_o !== 1'b0 || ovf_o !== 1'b0) begin
            errors++;
            $display("FAIL unf: res=%h u=%b z=%b o=%b want 00000001 1 0 0",
                     result, unf_o, zero_o, ovf_o);
        end
`else
        if (result !== 32'h00000000 || unf_o !== 1'b1 || zero_o !== 1'b1 || ovf_o !== 1'b0) begin
            errors++;
            $display("FAIL unf: res=%h u=%b z=%b o=%b want 00000000 1 1 0",
                     result, unf_o, zero_o, ovf_o);
        end
`endif
        @(negedge clk);
        out_ready = 1'b1;
        step();
        checks++;
        if (sticky_flags !== 2'b11) begin
            errors++;
            $display("FAIL unf_sticky: st=%b want 11", sticky_flags);
        end
        @(negedge clk);
        drive(1'b1, 1'b1, 8'h00, 1'b0, 23'h000000, 1'b0);
        flag_clr = 1'b1;
        step();
        in_valid = 1'b0;
        flag_clr = 1'b0;
        checks++;
        if (result !== 32'h80000000 || zero_o !== 1'b1 || unf_o !== 1'b0 ||
            sticky_flags !== 2'b00) begin
            errors++;
            $display("FAIL neg_zero: res=%h z=%b u=%b st=%b want 80000000 1 0 00",
                     result, zero_o, unf_o, sticky_flags);
        end
        step();
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        out_ready = 1'b0;
        drive(1'b1, 1'b0, 8'h81, 1'b0, 23'h000001, 1'b0);
        step();
        checks++;
        if (in_ready !== 1'b1 || result !== 32'h40800001) begin
            errors++;
            $display("FAIL bp_first: rdy=%b res=%h want 1 40800001", in_ready, result);
        end
        @(negedge clk);
        drive(1'b1, 1'b0, 8'h7F, 1'b0, 23'h000000, 1'b0);
        step();
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || result !== 32'h40800001) begin
            errors++;
            $display("FAIL bp_full: rdy=%b vld=%b res=%h want 0 1 40800001",
                     in_ready, out_valid, result);
        end
        @(negedge clk);
        drive(1'b1, 1'b1, 8'h82, 1'b0, 23'h200000, 1'b0);
        step();
        checks++;
        if (in_ready !== 1'b0 || result !== 32'h40800001) begin
            errors++;
            $display("FAIL bp_held: rdy=%b res=%h want 0 40800001", in_ready, result);
        end
        @(negedge clk);
        out_ready = 1'b1;
        step();
        checks++;
        if (in_ready !== 1'b1 || result !== 32'h3F800000) begin
            errors++;
            $display("FAIL bp_pop1: rdy=%b res=%h want 1 3f800000", in_ready, result);
        end
        step();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || result !== 32'hC1200000) begin
            errors++;
            $display("FAIL bp_pop2: vld=%b res=%h want 1 c1200000", out_valid, result);
        end
        step();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_drain: vld=%b rdy=%b want 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_nan();
        @(negedge clk);
        out_ready = 1'b0;
        drive(1'b1, 1'b1, 8'h00, 1'b1, 23'h000005, 1'b1);
        step();
        in_valid = 1'b0;
        checks++;
        if (result !== 32'h7FC00000 || {ovf_o, unf_o, zero_o} !== 3'b000) begin
            errors++;
            $display("FAIL nan: res=%h fl=%b%b%b want 7fc00000 000",
                     result, ovf_o, unf_o, zero_o);
        end
        @(negedge clk);
        out_ready = 1'b1;
        step();
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        out_ready = 1'b0;
        drive(1'b1, 1'b0, 8'h80, 1'b0, 23'h0, 1'b0);
        step();
        step();
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || sticky_flags !== 2'b00 ||
            result !== 32'h0) begin
            errors++;
            $display("FAIL reset_mid: vld=%b rdy=%b st=%b res=%h want 0 1 00 0",
                     out_valid, in_ready, sticky_flags, result);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_flag_clr();
        @(negedge clk);
        out_ready = 1'b0;
        drive(1'b1, 1'b0, 8'h20, 1'b1, 23'h0, 1'b0);
        step();
        in_valid = 1'b0;
        @(negedge clk);
        out_ready = 1'b1;
        flag_clr  = 1'b1;
        step();
        flag_clr = 1'b0;
        checks++;
        if (sticky_flags !== 2'b10) begin
            errors++;
            $display("FAIL clr_vs_set: st=%b want 10", sticky_flags);
        end
        @(negedge clk);
        flag_clr = 1'b1;
        step();
        flag_clr = 1'b0;
        checks++;
        if (sticky_flags !== 2'b00) begin
            errors++;
            $display("FAIL clr: st=%b want 00", sticky_flags);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_normal();
        test_overflow();
        test_underflow();
        test_back_to_back();
        test_nan();
        test_reset_mid();
        test_flag_clr();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
